// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch and a RUN/HALT state machine.
// Latency: a word returned with imem_rdy=1 at edge N is presented on ifid_* after edge N.
// Backpressure: stall holds everything, imem_rdy=0 inserts a bubble, and HLT stops fetching until reset.
module fetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_next,
  input  logic        branch,
  input  logic        stall,
  input  logic [15:0] imem_data,
  input  logic        imem_rdy,
  output logic [15:0] imem_addr,
  output logic        imem_ren,
  output logic [15:0] pc_cur,
  output logic [15:0] pc_inc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_inc,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] w_pc_nxt;
  logic [15:0] r_ifid_instr;
  logic [15:0] w_ifid_instr_nxt;
  logic [15:0] r_ifid_pc_inc;
  logic [15:0] w_ifid_pc_inc_nxt;
  logic        r_ifid_valid;
  logic        w_ifid_valid_nxt;
  logic [15:0] w_pc_inc;
  logic        w_is_hlt;

  // Sequential increment wraps naturally at 16 bits (0xFFFE -> 0x0000).
  assign w_pc_inc = r_pc + 16'h0002;
  assign w_is_hlt = (imem_data[15:12] == 4'hF);

  assign pc_cur      = r_pc;
  assign imem_addr   = r_pc;
  assign pc_inc      = w_pc_inc;
  assign imem_ren    = (r_state == RUN);
  assign halted      = (r_state == HALT);
  assign ifid_instr  = r_ifid_instr;
  assign ifid_pc_inc = r_ifid_pc_inc;
  assign ifid_valid  = r_ifid_valid;

  // State, PC and IF/ID registers; reset discards any in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_pc          <= 16'h0000;
      r_ifid_instr  <= 16'h0000;
      r_ifid_pc_inc <= 16'h0000;
      r_ifid_valid  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_ifid_instr  <= w_ifid_instr_nxt;
      r_ifid_pc_inc <= w_ifid_pc_inc_nxt;
      r_ifid_valid  <= w_ifid_valid_nxt;
    end
  end

  // Next-state decode: stall > branch > miss > fetch; HALT only drains the latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_ifid_instr_nxt  = r_ifid_instr;
    w_ifid_pc_inc_nxt = r_ifid_pc_inc;
    w_ifid_valid_nxt  = r_ifid_valid;
    case (r_state)
      RUN: begin
        if (stall) begin
          // hold everything
        end else if (branch) begin
          // Redirect targets are halfword aligned; bit 0 of the target is dropped.
          w_pc_nxt          = pc_next & 16'hFFFE;
          w_ifid_instr_nxt  = 16'h0000;
          w_ifid_pc_inc_nxt = 16'h0000;
          w_ifid_valid_nxt  = 1'b0;
        end else if (!imem_rdy) begin
          w_ifid_valid_nxt  = 1'b0;
        end else begin
          w_ifid_instr_nxt  = imem_data;
          w_ifid_pc_inc_nxt = w_pc_inc;
          w_ifid_valid_nxt  = 1'b1;
          if (w_is_hlt) begin
            // PC parks on the HLT address so a debugger sees where execution stopped.
            w_state_nxt = HALT;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
      end
      HALT: begin
        // The HLT entry is presented for exactly one non-stalled cycle.
        if (!stall) begin
          w_ifid_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic.
// Latency: outputs are compared against a reference model on every falling edge.
// Backpressure: stall, branch, imem_rdy and resets are exercised randomly.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc_next = 16'h0000;
  logic        branch = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_rdy = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_ren;
  logic [15:0] pc_cur;
  logic [15:0] pc_inc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_inc;
  logic        ifid_valid;
  logic        halted;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_next    (pc_next),
    .branch     (branch),
    .stall      (stall),
    .imem_data  (imem_data),
    .imem_rdy   (imem_rdy),
    .imem_addr  (imem_addr),
    .imem_ren   (imem_ren),
    .pc_cur     (pc_cur),
    .pc_inc     (pc_inc),
    .ifid_instr (ifid_instr),
    .ifid_pc_inc(ifid_pc_inc),
    .ifid_valid (ifid_valid),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Reference model: architectural view of the fetch stage.
  int unsigned m_pc = 0;
  int unsigned m_instr = 0;
  int unsigned m_pcinc = 0;
  bit          m_valid = 0;
  bit          m_halt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_instr = 0; m_pcinc = 0; m_valid = 0; m_halt = 0;
    end else if (m_halt) begin
      if (!stall) m_valid = 0;
    end else if (stall) begin
      // nothing moves
    end else if (branch) begin
      m_pc = (int'(pc_next) / 2) * 2;
      m_instr = 0; m_pcinc = 0; m_valid = 0;
    end else if (!imem_rdy) begin
      m_valid = 0;
    end else begin
      m_instr = imem_data;
      m_pcinc = (m_pc + 2) % 65536;
      m_valid = 1;
      if (imem_data >= 16'hF000) m_halt = 1;
      else m_pc = (m_pc + 2) % 65536;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge: all DUT outputs against the model.
  always @(negedge clk) begin
    check("pc_cur",      pc_cur,      16'(m_pc));
    check("imem_addr",   imem_addr,   16'(m_pc));
    check("pc_inc",      pc_inc,      16'((m_pc + 2) % 65536));
    check("ifid_instr",  ifid_instr,  16'(m_instr));
    check("ifid_pc_inc", ifid_pc_inc, 16'(m_pcinc));
    check("ifid_valid",  {15'd0, ifid_valid}, {15'd0, m_valid});
    check("halted",      {15'd0, halted},     {15'd0, m_halt});
    check("imem_ren",    {15'd0, imem_ren},   {15'd0, !m_halt});
  end

  // Apply one cycle of inputs from a falling edge; returns at the next falling edge.
  task automatic step(input logic rdy, input logic [15:0] dat, input logic br,
                      input logic [15:0] pcn, input logic st);
    imem_rdy = rdy; imem_data = dat; branch = br; pc_next = pcn; stall = st;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_pc", pc_cur, 16'h0000);
    check("rst_valid", {15'd0, ifid_valid}, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'h0000);
    check("rst_ren", {15'd0, imem_ren}, 16'h0001);
    rst_n = 1'b1;

    // Two sequential fetches from address 0
    step(1, 16'h1234, 0, 16'h0000, 0);
    check("f1_instr", ifid_instr, 16'h1234);
    check("f1_pcinc", ifid_pc_inc, 16'h0002);
    step(1, 16'h2345, 0, 16'h0000, 0);
    check("f2_instr", ifid_instr, 16'h2345);
    check("f2_pcinc", ifid_pc_inc, 16'h0004);
    check("f2_pc", pc_cur, 16'h0004);
    check("model_pc", 16'(m_pc), 16'h0004);

    // Misses at 0x0010
    step(0, 16'h0000, 1, 16'h0010, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 16'hDEAD, 0, 16'h0000, 0);
      check("miss_valid", {15'd0, ifid_valid}, 16'h0000);
      check("miss_pc", pc_cur, 16'h0010);
    end
    step(1, 16'h1111, 0, 16'h0000, 0);
    check("miss_done_valid", {15'd0, ifid_valid}, 16'h0001);
    check("miss_done_pcinc", ifid_pc_inc, 16'h0012);

    // Branch with odd target flushes IF/ID
    step(0, 16'h0000, 1, 16'h0020, 0);
    step(1, 16'h5555, 1, 16'h0101, 0);
    check("br_pc", pc_cur, 16'h0100);
    check("br_valid", {15'd0, ifid_valid}, 16'h0000);
    check("br_instr", ifid_instr, 16'h0000);

    // Stall beats branch
    step(0, 16'h0000, 1, 16'h002E, 0);
    step(1, 16'h0ABC, 0, 16'h0000, 0);
    check("pre_stall_pc", pc_cur, 16'h0030);
    for (int i = 0; i < 2; i++) begin
      step(1, 16'h7777, 1, 16'h0200, 1);
      check("stall_pc", pc_cur, 16'h0030);
      check("stall_instr", ifid_instr, 16'h0ABC);
      check("stall_valid", {15'd0, ifid_valid}, 16'h0001);
    end
    step(1, 16'h7777, 1, 16'h0200, 0);
    check("unstall_br_pc", pc_cur, 16'h0200);
    check("unstall_br_valid", {15'd0, ifid_valid}, 16'h0000);

    // HLT at 0x0040
    step(0, 16'h0000, 1, 16'h0040, 0);
    step(1, 16'hF000, 0, 16'h0000, 0);
    check("hlt_valid", {15'd0, ifid_valid}, 16'h0001);
    check("hlt_instr", ifid_instr, 16'hF000);
    check("hlt_pc", pc_cur, 16'h0040);
    check("hlt_halted", {15'd0, halted}, 16'h0001);
    check("hlt_ren", {15'd0, imem_ren}, 16'h0000);
    step(1, 16'h1234, 1, 16'h0300, 1);
    check("hlt_stall_valid", {15'd0, ifid_valid}, 16'h0001);
    for (int i = 0; i < 12; i++) begin
      step(1, 16'h1234, 1'(i % 2), 16'h0300, 0);
      check("halt_valid", {15'd0, ifid_valid}, 16'h0000);
      check("halt_pc", pc_cur, 16'h0040);
    end
    rst_n = 1'b0;
    #1;
    check("halt_rst_pc", pc_cur, 16'h0000);
    check("halt_rst_halted", {15'd0, halted}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // PC wrap
    step(0, 16'h0000, 1, 16'hFFFF, 0);
    check("wrap_pre_pc", pc_cur, 16'hFFFE);
    step(1, 16'h0123, 0, 16'h0000, 0);
    check("wrap_pcinc", ifid_pc_inc, 16'h0000);
    check("wrap_pc", pc_cur, 16'h0000);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        step(($urandom_range(0, 3) != 0),
             16'($urandom),
             ($urandom_range(0, 6) == 0),
             16'($urandom),
             ($urandom_range(0, 6) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
